lin_approx_counter: RTL and testbench
=====================================

LIN_APPROX_COUNTER -- requirements
Module: lin_approx_counter

Interface
REQ-001 Parameter SAMPLES_LOG2, default 20: a run consumes exactly 2^SAMPLES_LOG2 plaintext/ciphertext pairs.
REQ-002 Parameter PT_MASK, default 64'h2104_0080_0000_8000: plaintext bit selection mask for the linear approximation.
REQ-003 Parameter CT_MASK, default 64'h0000_8000_2104_0080: ciphertext bit selection mask for the linear approximation.
REQ-004 Parameter CNT_W, default SAMPLES_LOG2+1: width of count; it SHALL be able to hold 2^SAMPLES_LOG2.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a new run.
REQ-008 in_valid  input  1  pt/ct hold a valid pair this cycle; driven from the upstream LFSR/DES valid.
REQ-009 pt  input  64  plaintext from the upstream LFSR.
REQ-010 ct  input  64  ciphertext of pt.
REQ-011 count  output  CNT_W  number of accepted pairs for which the approximation held.
REQ-012 busy  output  1  a run is in progress.
REQ-013 done  output  1  level; the run is complete and count is final.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN and DONE; DRAIN is reachable only when PARITY_PIPE_EN is defined.
REQ-015 IDLE: start=1 at an edge SHALL give RUN at the next edge and clear count and the sample counter on that same edge.
REQ-016 RUN: every edge with in_valid=1 SHALL accept one pair and increment the sample counter, which is SAMPLES_LOG2 bits wide.
REQ-017 Parity SHALL equal XOR-reduce(pt & PT_MASK) XOR XOR-reduce(ct & CT_MASK); parity=0 SHALL increment count by 1.
REQ-018 Edges with in_valid=0 SHALL leave count and the sample counter unchanged; any gap pattern is legal.
REQ-019 The edge that accepts pair number 2^SAMPLES_LOG2 SHALL move RUN to DONE, or to DRAIN when the macro is defined.
REQ-020 The sample counter SHALL wrap to 0 on that final edge without affecting count.
REQ-021 DONE SHALL hold count and keep done=1 until start or reset.
REQ-022 start in DONE SHALL behave as in IDLE: next state RUN, count cleared, done=0.
REQ-023 In IDLE and DONE, in_valid, pt and ct SHALL be ignored.
REQ-024 In RUN and DRAIN, start SHALL be ignored.
REQ-025 busy SHALL be 1 exactly in RUN and DRAIN; done SHALL be 1 exactly in DONE; both are decoded from registered state.
REQ-026 count SHALL never overflow: its maximum is 2^SAMPLES_LOG2, and no saturation logic is required.

Reset
REQ-027 rst_n=0 at any edge, including mid-run, SHALL force state IDLE and clear count, sample counter and pipeline register; busy=0, done=0.
REQ-028 Reset SHALL take priority over start and in_valid at the same edge.

Configuration
REQ-029 Macro PARITY_PIPE_EN SHALL control a registered parity stage.
REQ-030 With PARITY_PIPE_EN defined: parity and in_valid SHALL be registered first, and count SHALL update one edge after acceptance.
REQ-031 With PARITY_PIPE_EN defined: the final acceptance SHALL go to DRAIN, and DRAIN SHALL go to DONE on the next edge, giving done one cycle later.
REQ-032 With PARITY_PIPE_EN defined: start in DONE SHALL also clear the pipeline register.
REQ-033 Without PARITY_PIPE_EN: parity SHALL be combinational, count SHALL update on the acceptance edge, and DRAIN SHALL be absent.
REQ-034 Final count SHALL be identical with and without the macro for the same stimulus.

Verification
REQ-035 SAMPLES_LOG2=4, PT_MASK=64'h1, CT_MASK=0, start, then 16 back-to-back pairs with pt=0 -> count=16; done=1 the cycle after the 16th valid, or two cycles after with the macro.
REQ-036 Same setup with pt=64'h1 for all pairs -> count=0, done=1, busy=0.
REQ-037 Same setup with pt alternating 0/1 and ct=64'hFFFF_FFFF_FFFF_FFFF, CT_MASK=64'h8000_0000_0000_0000 -> count=8.
REQ-038 in_valid high every third cycle for 16 pairs of pt=0 -> count=16; done only after the 16th valid; count unchanged on idle cycles.
REQ-039 rst_n low for one cycle after 5 accepted pairs -> count=0, busy=0, done=0; then start plus 16 pairs of pt=0 -> count=16.
REQ-040 After done, a start pulse together with in_valid=1 and start pulses during RUN -> count cleared next edge, that pair not counted, mid-run starts have no effect, and the final count equals a fresh run.

Source files
------------

// File: rtl/lin_approx_counter.sv
// lin_approx_counter: counts pt/ct pairs satisfying a masked linear approximation; define PARITY_PIPE_EN for a registered parity stage
module lin_approx_counter #(
    parameter int          SAMPLES_LOG2 = 20,
    parameter logic [63:0] PT_MASK      = 64'h2104_0080_0000_8000,
    parameter logic [63:0] CT_MASK      = 64'h0000_8000_2104_0080,
    parameter int          CNT_W        = SAMPLES_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [63:0]      pt,
    input  logic [63:0]      ct,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t                  state_q;
    logic [SAMPLES_LOG2-1:0] samp_q;
    logic [CNT_W-1:0]        count_q;
    logic                    busy_q, done_q;
    logic                    hit_d, acc, inc;
    // a pair is accepted only while running; the approximation holds on even masked parity
    always_comb begin
        acc   = (state_q == RUN) && in_valid;
        hit_d = ~((^(pt & PT_MASK)) ^ (^(ct & CT_MASK)));
    end
`ifdef PARITY_PIPE_EN
    localparam state_t LAST = DRAIN;
    logic pv_q, ph_q;
    // register accept strobe and parity; a start from IDLE/DONE has acc=0 so the stage clears itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= 1'b0;
            ph_q <= 1'b0;
        end else begin
            pv_q <= acc;
            ph_q <= hit_d;
        end
    end
    assign inc = pv_q & ph_q;
`else
    localparam state_t LAST = DONE;
    assign inc = acc & hit_d;
`endif
    // run control: sample counting, hit counting and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            samp_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (inc) count_q <= count_q + CNT_W'(1);
            case (state_q)
                RUN: if (acc) begin
                    samp_q <= samp_q + SAMPLES_LOG2'(1);
                    if (&samp_q) begin
                        state_q <= LAST;
                        busy_q  <= (LAST == DRAIN);
                        done_q  <= (LAST == DONE);
                    end
                end
`ifdef PARITY_PIPE_EN
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                default: if (start) begin
                    state_q <= RUN;
                    samp_q  <= '0;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_lin_approx_counter.sv
// tb_lin_approx_counter: directed checks of lin_approx_counter with 16-sample runs
module tb_lin_approx_counter;
`ifdef PARITY_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [63:0] pt, ct;
    logic [4:0]  count;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;

    lin_approx_counter #(
        .SAMPLES_LOG2(4),
        .PT_MASK(64'h1),
        .CT_MASK(64'h8000_0000_0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .pt(pt), .ct(ct), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: pt=0, 1: pt=1, 2: pt alternates 0/1
    task automatic pairs(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            pt = (mode == 0) ? 64'h0 : (mode == 1) ? 64'h1 : 64'(i % 2);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_cnt);
        check({tag, "_done_early"}, 32'(done), 32'(LAT == 1));
        repeat (LAT - 1) tick();
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; pt = '0; ct = '0;
        tick(); tick();
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("idle_ignores_valid", 32'(count), 0);
        check("idle_busy", 32'(busy), 0);

        pulse_start();
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        pairs(16, 0);
        finish_run("all_hold", 16);
        tick();
        check("done_holds", 32'(done), 1);
        check("done_count_holds", 32'(count), 16);

        pulse_start();
        pairs(16, 1);
        finish_run("none_hold", 0);

        ct = 64'hFFFF_FFFF_FFFF_FFFF;
        pulse_start();
        pairs(16, 2);
        finish_run("alternate", 8);
        ct = '0;

        pulse_start();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            pt = '0;
            tick();
            in_valid = 1'b0;
            tick();
            check("gap_count_a", 32'(count), 32'(i + 1));
            if (i < 15) begin
                check("gap_not_done", 32'(done), 0);
                tick();
                check("gap_count_b", 32'(count), 32'(i + 1));
            end
        end
        check("gap_done", 32'(done), 1);
        check("gap_busy", 32'(busy), 0);
        check("gap_final", 32'(count), 16);

        pulse_start();
        pairs(5, 0);
        tick();
        check("mid_count", 32'(count), 5);
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        check("midrst_count", 32'(count), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        pulse_start();
        pairs(16, 0);
        finish_run("after_rst", 16);

        start = 1'b1; in_valid = 1'b1; pt = '0;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("restart_count", 32'(count), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);
        tick();
        check("restart_no_pair", 32'(count), 0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            pt = '0;
            start = (i == 3 || i == 9) ? 1'b1 : 1'b0;
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        finish_run("midrun_start", 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
